// File: rtl/gate_self_test_if.sv
// Handshake and result bundle between the gate self-test controller and its environment.
// The gate block's result vector feeds back in as result_in.
interface gate_self_test_if;
    logic       start;
    logic [7:0] result_in;
    logic       a_out;
    logic       b_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_mask;
    logic       fail_valid;
    logic [1:0] fail_pattern;

    modport master (
        input  start,
        input  result_in,
        output a_out,
        output b_out,
        output busy,
        output done,
        output pass,
        output err_mask,
        output fail_valid,
        output fail_pattern
    );

    modport slave (
        output start,
        output result_in,
        input  a_out,
        input  b_out,
        input  busy,
        input  done,
        input  pass,
        input  err_mask,
        input  fail_valid,
        input  fail_pattern
    );
endinterface

// File: rtl/gate_self_test.sv
// BIST controller for the two-input basic-gate block: walks {a,b} through all four
// patterns, checks the eight gate outputs against golden values, reports mask and verdict.
module gate_self_test #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    gate_self_test_if.master bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned PAT_W = 2;
    localparam int unsigned VEC_W = 8;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CHECK   = 2'd2,
        DONE_ST = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [PAT_W-1:0]   pattern;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [VEC_W-1:0]   err_q;
    logic               fail_valid_q;
    logic [PAT_W-1:0]   fail_pattern_q;
    logic [VEC_W-1:0]   expected;
    logic [VEC_W-1:0]   mismatch;

    // Golden gate vector, bit order AND, OR, XOR, NOT, NAND, NOR, XNOR, BUFF from bit 0 up.
    function automatic logic [VEC_W-1:0] golden(input logic [PAT_W-1:0] p);
        logic a;
        logic b;
        a = p[1];
        b = p[0];
        return {a, ~(a ^ b), ~(a | b), ~(a & b), ~a, a ^ b, a | b, a & b};
    endfunction

    assign expected = golden(pattern);
    assign mismatch = bus.result_in ^ expected;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            pattern        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            err_q          <= '0;
            fail_valid_q   <= 1'b0;
            fail_pattern_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        err_q          <= '0;
                        fail_valid_q   <= 1'b0;
                        fail_pattern_q <= '0;
                        pass_q         <= 1'b0;
                        pattern        <= '0;
                        cnt            <= CNT_LOAD;
                        busy_q         <= 1'b1;
                        state          <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CHECK: begin
                    err_q <= err_q | mismatch;
                    if ((|mismatch) && !fail_valid_q) begin
                        fail_valid_q   <= 1'b1;
                        fail_pattern_q <= pattern;
                    end
                    // Last pattern closes the run; verdict covers this sample too.
                    if (pattern == PAT_W'(3)) begin
                        done_q  <= 1'b1;
                        pass_q  <= ~|(err_q | mismatch);
                        pattern <= '0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        pattern <= pattern + PAT_W'(1);
                        cnt     <= CNT_LOAD;
                        state   <= SETTLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.a_out        = pattern[1];
    assign bus.b_out        = pattern[0];
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.err_mask     = err_q;
    assign bus.fail_valid   = fail_valid_q;
    assign bus.fail_pattern = fail_pattern_q;
endmodule

// File: tb/tb_gate_self_test.sv
// Bench for gate_self_test: two instances (SETTLE_CYCLES 1 and 3), a timeline-based
// reference model compared every cycle, plus directed literal checks.
module tb_gate_self_test;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_self_test_if bus1();
    gate_self_test_if bus3();

    logic [7:0] sa0 = 8'h00;
    logic [7:0] sa1 = 8'h00;
    logic [7:0] inv = 8'h00;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    typedef struct packed {
        logic       run;
        logic [7:0] t;
        logic [1:0] pat;
        logic       busy;
        logic       done;
        logic       pass;
        logic       fv;
        logic [1:0] fp;
        logic [7:0] err;
    } model_t;

    model_t m1 = '0;
    model_t m3 = '0;

    function automatic logic [7:0] ideal(input logic [1:0] p);
        logic a;
        logic b;
        logic [7:0] g;
        a = p[1];
        b = p[0];
        g[0] = a & b;
        g[1] = a | b;
        g[2] = a ^ b;
        g[3] = ~a;
        g[4] = ~(a & b);
        g[5] = ~(a | b);
        g[6] = ~(a ^ b);
        g[7] = a;
        return g;
    endfunction

    function automatic logic [7:0] gate_block(input logic [1:0] p, input logic [7:0] s0,
                                              input logic [7:0] s1, input logic [7:0] iv);
        return ((ideal(p) & ~s0) | s1) ^ iv;
    endfunction

    assign bus1.result_in = gate_block({bus1.a_out, bus1.b_out}, sa0, sa1, inv);
    assign bus3.result_in = gate_block({bus3.a_out, bus3.b_out}, 8'h00, 8'h00, 8'h00);

    gate_self_test #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    gate_self_test #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // Model: t counts edges since the accepting edge; a sample falls on every multiple of s+1.
    function automatic model_t model_step(input model_t m, input logic rst, input logic start,
                                          input int s, input logic [7:0] s0,
                                          input logic [7:0] s1, input logic [7:0] iv);
        model_t n;
        int k;
        logic [7:0] mm;
        n = m;
        if (!rst) begin
            n = '0;
        end else begin
            n.done = 1'b0;
            if (!m.run) begin
                if (start) begin
                    n      = '0;
                    n.run  = 1'b1;
                    n.busy = 1'b1;
                end
            end else begin
                n.t = m.t + 8'd1;
                if ((int'(n.t) % (s + 1)) == 0) begin
                    k  = int'(n.t) / (s + 1) - 1;
                    mm = gate_block(2'(k), s0, s1, iv) ^ ideal(2'(k));
                    n.err = m.err | mm;
                    if (mm != 8'h00 && !m.fv) begin
                        n.fv = 1'b1;
                        n.fp = 2'(k);
                    end
                    if (k == 3) begin
                        n.done = 1'b1;
                        n.pass = (n.err == 8'h00);
                        n.run  = 1'b0;
                        n.busy = 1'b0;
                        n.pat  = 2'b00;
                    end else begin
                        n.pat = 2'(k + 1);
                    end
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m1 <= model_step(m1, rst_n, bus1.start, 1, sa0, sa1, inv);
        m3 <= model_step(m3, rst_n, bus3.start, 3, 8'h00, 8'h00, 8'h00);
    end

    function automatic logic [15:0] pack(input logic a, input logic b, input logic busy,
                                         input logic done, input logic pass, input logic fv,
                                         input logic [1:0] fp, input logic [7:0] err);
        return {a, b, busy, done, pass, fv, (fv ? fp : 2'b00), err};
    endfunction

    function automatic logic [15:0] pack_model(input model_t m);
        return pack(m.pat[1], m.pat[0], m.busy, m.done, m.pass, m.fv, m.fp, m.err);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    logic [15:0] act1;
    logic [15:0] act3;
    assign act1 = pack(bus1.a_out, bus1.b_out, bus1.busy, bus1.done, bus1.pass,
                       bus1.fail_valid, bus1.fail_pattern, bus1.err_mask);
    assign act3 = pack(bus3.a_out, bus3.b_out, bus3.busy, bus3.done, bus3.pass,
                       bus3.fail_valid, bus3.fail_pattern, bus3.err_mask);

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dut1_cycle", 32'(act1), 32'(pack_model(m1)));
            chk("dut3_cycle", 32'(act3), 32'(pack_model(m3)));
        end
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge just after the accepting edge (edge 0).
    task automatic go1();
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
    endtask

    initial begin
        int dones;
        int done_edges[$];
        bus1.start = 1'b0;
        bus3.start = 1'b0;

        ticks(2);
        chk_en = 1'b1;
        chk("rst_dut1_all_zero", 32'(act1), 32'h0);
        chk("rst_dut3_all_zero", 32'(act3), 32'h0);
        rst_n = 1'b1;
        ticks(1);

        // Fault-free run, SETTLE_CYCLES=1
        go1();
        chk("t1_pat_e0", 32'({bus1.a_out, bus1.b_out}), 32'h0);
        chk("t1_busy_e0", 32'(bus1.busy), 32'h1);
        ticks(2);
        chk("t1_pat_e2", 32'({bus1.a_out, bus1.b_out}), 32'h1);
        ticks(2);
        chk("t1_pat_e4", 32'({bus1.a_out, bus1.b_out}), 32'h2);
        ticks(2);
        chk("t1_pat_e6", 32'({bus1.a_out, bus1.b_out}), 32'h3);
        ticks(1);
        chk("t1_done_e7", 32'(bus1.done), 32'h0);
        ticks(1);
        chk("t1_done_e8", 32'(bus1.done), 32'h1);
        chk("t1_busy_e8", 32'(bus1.busy), 32'h0);
        chk("t1_pass", 32'(bus1.pass), 32'h1);
        chk("t1_err", 32'(bus1.err_mask), 32'h00);
        chk("t1_fv", 32'(bus1.fail_valid), 32'h0);
        chk("t1_model_done", 32'(m1.done), 32'h1);
        ticks(1);
        chk("t1_done_e9", 32'(bus1.done), 32'h0);

        // XOR stuck at 0
        sa0 = 8'h04;
        go1();
        ticks(8);
        chk("t2_err", 32'(bus1.err_mask), 32'h04);
        chk("t2_fv", 32'(bus1.fail_valid), 32'h1);
        chk("t2_fp", 32'(bus1.fail_pattern), 32'h1);
        chk("t2_pass", 32'(bus1.pass), 32'h0);
        chk("t2_model_err", 32'(m1.err), 32'h04);
        sa0 = 8'h00;

        // BUFF inverted, then a clean run
        inv = 8'h80;
        go1();
        ticks(8);
        chk("t3_err", 32'(bus1.err_mask), 32'h80);
        chk("t3_fp", 32'(bus1.fail_pattern), 32'h0);
        chk("t3_fv", 32'(bus1.fail_valid), 32'h1);
        chk("t3_pass", 32'(bus1.pass), 32'h0);
        inv = 8'h00;
        go1();
        ticks(8);
        chk("t3b_pass", 32'(bus1.pass), 32'h1);
        chk("t3b_err", 32'(bus1.err_mask), 32'h00);

        // SETTLE_CYCLES=3 with starts re-pulsed mid-run at edges 5 and 10
        bus3.start = 1'b1;
        @(negedge clk);
        dones = 0;
        for (int e = 1; e <= 30; e++) begin
            bus3.start = (e == 5 || e == 10);
            @(negedge clk);
            if (e == 10) chk("t4_pat_e10", 32'({bus3.a_out, bus3.b_out}), 32'h2);
            if (e == 15) chk("t4_done_e15", 32'(bus3.done), 32'h0);
            if (bus3.done) begin
                dones++;
                chk("t4_done_edge", 32'(e), 32'd16);
                chk("t4_pass", 32'(bus3.pass), 32'h1);
            end
        end
        bus3.start = 1'b0;
        chk("t4_done_count", 32'(dones), 32'd1);

        // Reset mid faulty run, then a clean run
        inv = 8'h80;
        go1();
        ticks(2);
        chk("t5_fv_e2", 32'(bus1.fail_valid), 32'h1);
        rst_n = 1'b0;
        ticks(1);
        chk("t5_rst_all_zero", 32'(act1), 32'h0);
        rst_n = 1'b1;
        inv = 8'h00;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus1.done) dones++;
        end
        chk("t5_no_done_after_rst", 32'(dones), 32'd0);
        go1();
        ticks(8);
        chk("t5_done_rerun", 32'(bus1.done), 32'h1);
        chk("t5_pass_rerun", 32'(bus1.pass), 32'h1);

        // start held high: back-to-back runs
        bus1.start = 1'b1;
        @(negedge clk);
        for (int e = 1; e <= 26; e++) begin
            @(negedge clk);
            if (bus1.done) done_edges.push_back(e);
            if (e == 8) chk("t6_busy_e8", 32'(bus1.busy), 32'h0);
            if (e == 9) chk("t6_busy_e9", 32'(bus1.busy), 32'h1);
        end
        bus1.start = 1'b0;
        chk("t6_done_count", 32'(done_edges.size()), 32'd3);
        if (done_edges.size() == 3) begin
            chk("t6_done_1", 32'(done_edges[0]), 32'd8);
            chk("t6_done_2", 32'(done_edges[1]), 32'd17);
            chk("t6_done_3", 32'(done_edges[2]), 32'd26);
        end
        ticks(2);
        chk("t6_idle_after", 32'(bus1.busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
